ws2812_apb_driver: RTL and testbench
====================================

Name: ws2812_apb_driver

Overview:
- APB3 peripheral that drives a chain of WS2812-style addressable RGB LEDs over a single-wire NRZ pulse-width output.
- Generalises the fixed 8-pixel driver: parametrised pixel count and bit timing, readable pixel RAM, software-triggered or auto-refresh frames, busy/done status, frame counter and interrupt.
- Sits on the APB3 fabric beside the other memory-mapped I/O blocks; firmware writes colours, then starts a frame.

Parameters:
- NUM_LEDS, 8, pixels in chain; legal 1..64.
- BIT_CYCLES, 125, PCLK cycles per data bit (1.25 us at 100 MHz).
- T0H_CYCLES, 40, high time for a 0 bit; must be < T1H_CYCLES.
- T1H_CYCLES, 80, high time for a 1 bit; must be < BIT_CYCLES.
- RESET_CYCLES, 5000, low latch time after the last bit.

Ports:
- PCLK  in  1  clock
- PRESERN  in  1  reset; synchronous, active-low
- PSEL  in  1  peripheral select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write
- PADDR  in  32  byte address; only [8:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, combinational from PADDR
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- LED  out  1  serial pixel data
- IRQ  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Write strobe is PSEL & PENABLE & PWRITE. All state is updated on the PCLK rising edge.
- Register map:
  - 0x000 CTRL: bit0 START (write-1 pulse, reads 0); bit1 AUTO; bit2 IRQ_EN.
  - 0x004 STATUS: bit0 BUSY (read-only); bit1 DONE (sticky, write-1-to-clear).
  - 0x008 FRAME_CNT: [15:0] count of completed frames, read-only, wraps 0xFFFF->0.
  - 0x100 + 4*i: PIXEL[i][23:0], read/write, for i < NUM_LEDS. Upper bits write-ignored and read 0.
  - Unmapped or out-of-range addresses: reads return 0, writes are ignored, no error.
- Reset (PRESERN=0 at an edge): LED=0, IRQ=0, state IDLE, CTRL=0, DONE=0, FRAME_CNT=0, all PIXEL=0. Reset takes effect immediately, mid-frame included; the frame is abandoned with no latch period.
- FSM states:
  - IDLE: LED=0. A START write moves to SEND. On the next edge BUSY=1, led_idx=0, shift register = PIXEL[0], bit pointer=23, pwm=0.
  - SEND: transmit MSB first (bit23 first, i.e. GRB order). LED=1 while pwm < THx, where THx = T1H_CYCLES if the current bit is 1, else T0H_CYCLES; LED=0 otherwise. pwm counts 0..BIT_CYCLES-1, then the next bit starts. After bit0, the next pixel is loaded into the shift register. Pixel RAM writes during SEND therefore affect only pixels not yet loaded. After bit0 of pixel NUM_LEDS-1, go to LATCH.
  - LATCH: LED=0 for exactly RESET_CYCLES cycles. On exit: DONE=1 and FRAME_CNT+1. If AUTO=1, go straight to SEND (BUSY stays 1). Otherwise go to IDLE and BUSY=0.
- Timing:
  - LED rises one cycle after the START access cycle.
  - Frame duration is NUM_LEDS*24*BIT_CYCLES + RESET_CYCLES cycles.
  - BIT_CYCLES + T1H_CYCLES ≤ 2^counter width, with no overflow; size counters with $clog2.
- Boundary cases:
  - START while BUSY: ignored, no queueing.
  - Clearing AUTO mid-frame: the current frame and its latch complete, then IDLE.
  - A DONE set and a W1C in the same cycle: set wins.
  - A CTRL write with START=1 and AUTO=1 starts a frame and enables repeat.
  - NUM_LEDS=1: the frame is 24 bits.

Test Plan:
All scenarios use NUM_LEDS=2, BIT_CYCLES=10, T0H=3, T1H=7, RESET=20.
1. Reset, then read all registers -> every register 0; LED=0; IRQ=0.
2. Write PIXEL0=0xA50000, PIXEL1=0x000001, then START -> 48 bit slots.
   - Slot 0 is high 7 cycles; slot 1 is high 3 cycles; pattern 1010 0101, then zeros.
   - Slot 47 is high 7 cycles, followed by 20 low cycles.
   - BUSY 1→0 at cycle 500 after START; DONE=1; FRAME_CNT=1.
3. Set IRQ_EN=1 and complete a frame -> IRQ=1. Write STATUS=0x2 -> IRQ=0 next cycle.
4. Set AUTO=1 and START, wait 3 frames, clear AUTO -> FRAME_CNT=3 or 4 (exactly 1 more than at clear time). BUSY never drops between frames.
5. Issue START at bit slot 10 of a frame -> no restart. Write PIXEL1=0xFFFFFF during pixel0 -> pixel1 slots are all high 7 cycles. A write to PIXEL0 during pixel1 has no effect on the current frame.
6. Drive PRESERN=0 at slot 30 -> LED=0 and BUSY=0 next edge; pixels read 0. Read 0x108 (out of range) -> 0.

Source files
------------

// File: rtl/ws2812_apb_driver.sv
// APB3 peripheral that streams a pixel RAM to a WS2812-style LED chain as NRZ pulses.
// Supports single-shot or auto-repeating frames, a frame counter and a DONE interrupt.
module ws2812_apb_driver #(
    parameter int NUM_LEDS     = 8,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int RESET_CYCLES = 5000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        LED,
    output logic        IRQ
);

    localparam int PWM_W = $clog2(BIT_CYCLES + T1H_CYCLES);
    localparam int LAT_W = $clog2(RESET_CYCLES + 1);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [6:0] A_CTRL   = 7'd0;
    localparam logic [6:0] A_STATUS = 7'd1;
    localparam logic [6:0] A_FCNT   = 7'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state_r;
    logic              busy_r;
    logic              auto_r;
    logic              irq_en_r;
    logic              done_r;
    logic              irq_r;
    logic              led_r;
    logic [15:0]       frame_cnt_r;
    logic [23:0]       shift_r;
    logic [4:0]        bit_ptr_r;
    logic [PWM_W-1:0]  pwm_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [IDX_W-1:0]  led_idx_r;
    logic [23:0]       pix_r [NUM_LEDS];

    logic              wr_s;
    logic [6:0]        word_s;
    logic [5:0]        pix_sel_s;
    logic              ctrl_wr_s;
    logic              status_wr_s;
    logic              pix_wr_s;
    logic              start_s;
    logic              frame_end_s;
    logic              done_nxt_s;
    logic              irq_en_nxt_s;
    logic [IDX_W-1:0]  next_idx_s;
    logic [23:0]       next_pix_s;
    logic              unused_s;

    // High phase of a bit slot: a 1 bit stays high longer than a 0 bit.
    function automatic logic bit_level(input logic b, input logic [PWM_W-1:0] p);
        if (b) begin
            return (p < PWM_W'(T1H_CYCLES));
        end else begin
            return (p < PWM_W'(T0H_CYCLES));
        end
    endfunction

    assign wr_s        = PSEL & PENABLE & PWRITE;
    assign word_s      = PADDR[8:2];
    assign pix_sel_s   = word_s[5:0];
    assign ctrl_wr_s   = wr_s && (word_s == A_CTRL);
    assign status_wr_s = wr_s && (word_s == A_STATUS);
    assign pix_wr_s    = wr_s && word_s[6];
    assign start_s     = ctrl_wr_s & PWDATA[0];
    assign frame_end_s = (state_r == ST_LATCH) && (lat_cnt_r == LAT_W'(RESET_CYCLES - 1));
    assign next_idx_s  = led_idx_r + IDX_W'(1);
    assign next_pix_s  = pix_r[next_idx_s];
    assign unused_s    = ^{PADDR[31:9], PADDR[1:0], PWDATA[31:24]};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign LED     = led_r;
    assign IRQ     = irq_r;

    // Next DONE / IRQ_EN values; a frame completion outranks a same-cycle W1C.
    always_comb begin
        done_nxt_s   = done_r;
        irq_en_nxt_s = irq_en_r;
        if (frame_end_s) begin
            done_nxt_s = 1'b1;
        end else if (status_wr_s && PWDATA[1]) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        if (ctrl_wr_s) begin
            irq_en_nxt_s = PWDATA[2];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // Pixel RAM; only in-range indices are writable.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (!PRESERN) begin
                pix_r[i] <= 24'd0;
            end else if (pix_wr_s && (pix_sel_s == 6'(i))) begin
                pix_r[i] <= PWDATA[23:0];
            end
        end
    end

    // Control register bits.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            auto_r   <= 1'b0;
            irq_en_r <= 1'b0;
        end else begin
            irq_en_r <= irq_en_nxt_s;
            if (ctrl_wr_s) begin
                auto_r <= PWDATA[1];
            end
        end
    end

    // Frame sequencer: bit-slot PWM, pixel fetch, latch period and status.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            irq_r       <= 1'b0;
            led_r       <= 1'b0;
            frame_cnt_r <= 16'd0;
            shift_r     <= 24'd0;
            bit_ptr_r   <= 5'd0;
            pwm_r       <= PWM_W'(0);
            lat_cnt_r   <= LAT_W'(0);
            led_idx_r   <= IDX_W'(0);
        end else begin
            done_r <= done_nxt_s;
            irq_r  <= done_nxt_s & irq_en_nxt_s;
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    led_r <= 1'b0;
                    if (start_s) begin
                        state_r   <= ST_SEND;
                        busy_r    <= 1'b1;
                        led_idx_r <= IDX_W'(0);
                        shift_r   <= pix_r[0];
                        bit_ptr_r <= 5'd23;
                        pwm_r     <= PWM_W'(0);
                        led_r     <= bit_level(pix_r[0][23], PWM_W'(0));
                    end
                end
                ST_SEND: begin
                    if (pwm_r == PWM_W'(BIT_CYCLES - 1)) begin
                        pwm_r <= PWM_W'(0);
                        if (bit_ptr_r == 5'd0) begin
                            if (led_idx_r == IDX_W'(NUM_LEDS - 1)) begin
                                state_r   <= ST_LATCH;
                                lat_cnt_r <= LAT_W'(0);
                                led_r     <= 1'b0;
                            end else begin
                                led_idx_r <= next_idx_s;
                                shift_r   <= next_pix_s;
                                bit_ptr_r <= 5'd23;
                                led_r     <= bit_level(next_pix_s[23], PWM_W'(0));
                            end
                        end else begin
                            bit_ptr_r <= bit_ptr_r - 5'd1;
                            led_r     <= bit_level(shift_r[bit_ptr_r - 5'd1], PWM_W'(0));
                        end
                    end else begin
                        pwm_r <= pwm_r + PWM_W'(1);
                        led_r <= bit_level(shift_r[bit_ptr_r], pwm_r + PWM_W'(1));
                    end
                end
                ST_LATCH: begin
                    led_r <= 1'b0;
                    if (frame_end_s) begin
                        if (auto_r) begin
                            state_r   <= ST_SEND;
                            led_idx_r <= IDX_W'(0);
                            shift_r   <= pix_r[0];
                            bit_ptr_r <= 5'd23;
                            pwm_r     <= PWM_W'(0);
                            led_r     <= bit_level(pix_r[0][23], PWM_W'(0));
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    led_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read mux, combinational from PADDR.
    always_comb begin
        PRDATA = 32'd0;
        if (word_s[6]) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (pix_sel_s == 6'(i)) begin
                    PRDATA = {8'd0, pix_r[i]};
                end
            end
        end else begin
            case (word_s)
                A_CTRL:   PRDATA = {29'd0, irq_en_r, auto_r, 1'b0};
                A_STATUS: PRDATA = {30'd0, done_r, busy_r};
                A_FCNT:   PRDATA = {16'd0, frame_cnt_r};
                default:  PRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_apb_driver.sv
// Randomised self-checking bench for ws2812_apb_driver; the LED waveform is
// predicted from pixel values with slot arithmetic.
module tb_ws2812_apb_driver;

    localparam int NL    = 2;
    localparam int BC    = 10;
    localparam int T0    = 3;
    localparam int T1    = 7;
    localparam int RC    = 20;
    localparam int DATA  = NL * 24 * BC;
    localparam int FRAME = DATA + RC;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = 32'h4;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        LED;
    logic        IRQ;

    int   n_checks = 0;
    int   n_fail = 0;
    int   fc_exp = 0;
    logic led_obs [4096];
    logic busy_obs [4096];

    ws2812_apb_driver #(
        .NUM_LEDS(NL), .BIT_CYCLES(BC), .T0H_CYCLES(T0), .T1H_CYCLES(T1), .RESET_CYCLES(RC)
    ) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .LED(LED), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h4;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        #1 d = PRDATA;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PADDR = 32'h4;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check_eq(tag, d, exp);
    endtask

    // Record LED and BUSY (PADDR parked on STATUS) once per cycle.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            led_obs[c]  = LED;
            busy_obs[c] = PRDATA[0];
            @(posedge PCLK);
        end
    endtask

    function automatic logic model_led(input int c, input logic [23:0] p0, input logic [23:0] p1, input bit rpt);
        int f;
        int slot;
        logic [23:0] px;
        if (!rpt && c >= FRAME) return 1'b0;
        f = c % FRAME;
        if (f >= DATA) return 1'b0;
        slot = f / BC;
        px = (slot < 24) ? p0 : p1;
        return ((f % BC) < (px[23 - (slot % 24)] ? T1 : T0));
    endfunction

    task automatic wave_check(input string tag, input int n, input logic [23:0] p0, input logic [23:0] p1, input bit rpt);
        int mism = 0;
        for (int c = 0; c < n; c++) begin
            if (led_obs[c] !== model_led(c, p0, p1, rpt)) mism++;
        end
        check_eq(tag, mism, 0);
    endtask

    function automatic int slot_high(input int s);
        int h = 0;
        for (int k = 0; k < BC; k++) begin
            if (led_obs[s * BC + k] === 1'b1) h++;
        end
        return h;
    endfunction

    function automatic int busy_fall(input int n);
        for (int c = 0; c < n; c++) begin
            if (busy_obs[c] !== 1'b1) return c;
        end
        return -1;
    endfunction

    initial begin
        logic [23:0] p0;
        logic [23:0] p1;
        logic [23:0] p0_new;
        int busy_gaps;
        bit stopped;

        // 1. reset state and register map
        repeat (3) @(posedge PCLK);
        #1 PRESERN = 1'b1;
        check_eq("rst_led", LED, 1'b0);
        check_eq("rst_irq", IRQ, 1'b0);
        read_check("rst_ctrl", 32'h000, 32'h0);
        read_check("rst_status", 32'h004, 32'h0);
        read_check("rst_fcnt", 32'h008, 32'h0);
        read_check("rst_pix0", 32'h100, 32'h0);
        read_check("rst_pix1", 32'h104, 32'h0);
        p0 = 24'($urandom);
        apb_write(32'h104, {8'hFF, p0});
        read_check("pix_upper_mask", 32'h104, {8'h00, p0});
        apb_write(32'h108, 32'h00123456);
        read_check("pix_out_of_range", 32'h108, 32'h0);
        read_check("unmapped", 32'h00C, 32'h0);
        read_check("ctrl_start_reads0", 32'h000, 32'h0);

        // 2. fixed pattern frame
        apb_write(32'h100, 32'hA50000);
        apb_write(32'h104, 32'h000001);
        apb_write(32'h000, 32'h1);
        capture(FRAME + 10);
        check_eq("slot0_high", slot_high(0), 7);
        check_eq("slot1_high", slot_high(1), 3);
        check_eq("slot47_high", slot_high(47), 7);
        check_eq("wave_fixed", 0, 0 + 0) ;
        wave_check("wave_fixed_pattern", FRAME + 10, 24'hA50000, 24'h000001, 1'b0);
        check_eq("busy_fall", busy_fall(FRAME + 10), FRAME);
        fc_exp = 1;
        read_check("status_done", 32'h004, 32'h2);
        read_check("fcnt_1", 32'h008, 32'(fc_exp));

        // 3. IRQ on random frame
        apb_write(32'h004, 32'h2);
        read_check("done_w1c", 32'h004, 32'h0);
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        apb_write(32'h100, {8'h0, p0});
        apb_write(32'h104, {8'h0, p1});
        apb_write(32'h000, 32'h5);
        check_eq("irq_before_done", IRQ, 1'b0);
        capture(FRAME + 10);
        wave_check("wave_rand", FRAME + 10, p0, p1, 1'b0);
        check_eq("busy_fall_rand", busy_fall(FRAME + 10), FRAME);
        #1 check_eq("irq_set", IRQ, 1'b1);
        apb_write(32'h004, 32'h2);
        check_eq("irq_clear", IRQ, 1'b0);
        fc_exp++;

        // 4. auto-refresh frames
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        apb_write(32'h100, {8'h0, p0});
        apb_write(32'h104, {8'h0, p1});
        apb_write(32'h000, 32'h3);
        capture(3 * FRAME);
        wave_check("wave_auto", 3 * FRAME, p0, p1, 1'b1);
        busy_gaps = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (busy_obs[c] !== 1'b1) busy_gaps++;
        end
        check_eq("auto_busy_gaps", busy_gaps, 0);
        read_check("auto_fcnt3", 32'h008, 32'(fc_exp + 3));
        apb_write(32'h000, 32'h0);
        stopped = 1'b0;
        for (int c = 0; c < 2 * FRAME && !stopped; c++) begin
            @(posedge PCLK);
            #1 if (PRDATA[0] == 1'b0) stopped = 1'b1;
        end
        check_eq("auto_stop", stopped, 1'b1);
        fc_exp += 4;
        read_check("auto_fcnt_final", 32'h008, 32'(fc_exp));

        // 5. START while busy ignored; pixel writes during SEND
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        p0_new = 24'($urandom);
        apb_write(32'h100, {8'h0, p0});
        apb_write(32'h104, {8'h0, p1});
        apb_write(32'h000, 32'h1);
        fork
            capture(FRAME + 10);
            begin
                repeat (98) @(posedge PCLK);
                apb_write(32'h000, 32'h1);
                apb_write(32'h104, 32'hFFFFFF);
                repeat (200) @(posedge PCLK);
                apb_write(32'h100, {8'h0, p0_new});
            end
        join
        wave_check("wave_midframe_writes", FRAME + 10, p0, 24'hFFFFFF, 1'b0);
        fc_exp++;
        read_check("fcnt_no_restart", 32'h008, 32'(fc_exp));
        read_check("pix0_updated", 32'h100, {8'h0, p0_new});

        // 6. reset mid-frame at slot 30
        apb_write(32'h000, 32'h1);
        repeat (299) @(posedge PCLK);
        #1 check_eq("pre_reset_busy", PRDATA[0], 1'b1);
        PRESERN = 1'b0;
        @(posedge PCLK);
        #1 check_eq("reset_led", LED, 1'b0);
        check_eq("reset_busy", PRDATA[0], 1'b0);
        PRESERN = 1'b1;
        read_check("reset_pix0", 32'h100, 32'h0);
        read_check("reset_pix1", 32'h104, 32'h0);
        read_check("reset_fcnt", 32'h008, 32'h0);
        read_check("oor_read", 32'h108, 32'h0);
        check_eq("reset_led_idle", LED, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
